state_sequencer: RTL and testbench

Multi-cycle CPU control-unit state register and next-state logic. Walks each instruction through IF, ID, EXE, MEM and WB according to its opcode. Drives the 3-bit `State` bus that the control-signal decoder consumes in the same cycle. Also detects halt and illegal opcodes, and optionally counts cycles and retired instructions.

---
 rtl/ctrl_pkg.sv | 40 ++++
 rtl/opcode_class_decode.sv | 23 ++
 rtl/state_sequencer.sv | 117 +++++++++++
 tb/tb_state_sequencer.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared control-unit definitions: state encoding, opcode values and opcode classes.
package ctrl_pkg;

  typedef enum logic [2:0] {
    S_IF   = 3'b000,
    S_ID   = 3'b001,
    S_EXE  = 3'b010,
    S_WB   = 3'b011,
    S_MEM  = 3'b100,
    S_HALT = 3'b111
  } state_t;

  localparam logic [5:0] OP_ADD   = 6'b000000;
  localparam logic [5:0] OP_SUB   = 6'b000001;
  localparam logic [5:0] OP_ADDIU = 6'b000010;
  localparam logic [5:0] OP_AND   = 6'b010000;
  localparam logic [5:0] OP_ANDI  = 6'b010001;
  localparam logic [5:0] OP_OR    = 6'b010010;
  localparam logic [5:0] OP_SLL   = 6'b011000;
  localparam logic [5:0] OP_SLT   = 6'b100110;
  localparam logic [5:0] OP_SLTI  = 6'b100111;
  localparam logic [5:0] OP_SW    = 6'b110000;
  localparam logic [5:0] OP_LW    = 6'b110001;
  localparam logic [5:0] OP_BEQ   = 6'b110100;
  localparam logic [5:0] OP_BNE   = 6'b110101;
  localparam logic [5:0] OP_BLTZ  = 6'b110110;
  localparam logic [5:0] OP_J     = 6'b111000;
  localparam logic [5:0] OP_HALT  = 6'b111111;

  typedef enum logic [2:0] {
    CLS_ALU,
    CLS_STORE,
    CLS_LOAD,
    CLS_BRANCH,
    CLS_JUMP,
    CLS_HALT,
    CLS_ILLEGAL
  } op_class_t;

endpackage

// File: rtl/opcode_class_decode.sv
// Purely combinational opcode to instruction-class decoder.
module opcode_class_decode
  import ctrl_pkg::*;
(
  input  logic [5:0] Opcode,
  output op_class_t  OpClass
);

  always_comb begin
    OpClass = CLS_ILLEGAL;
    unique case (Opcode)
      OP_ADD, OP_SUB, OP_ADDIU, OP_AND, OP_ANDI,
      OP_OR, OP_SLL, OP_SLT, OP_SLTI:  OpClass = CLS_ALU;
      OP_SW:                           OpClass = CLS_STORE;
      OP_LW:                           OpClass = CLS_LOAD;
      OP_BEQ, OP_BNE, OP_BLTZ:         OpClass = CLS_BRANCH;
      OP_J:                            OpClass = CLS_JUMP;
      OP_HALT:                         OpClass = CLS_HALT;
      default:                         OpClass = CLS_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/state_sequencer.sv
// Multi-cycle control-unit state register and next-state logic.
// Optional performance counters are enabled by defining STATE_SEQ_PERF_CNT_EN.
module state_sequencer
  import ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic [5:0]       Opcode,
  input  logic             Stall,
  output logic [2:0]       State,
  output logic             InsDone,
  output logic             Halted,
  output logic             Illegal
`ifdef STATE_SEQ_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] CycleCnt,
  output logic [CNT_W-1:0] InsCnt
`endif
);

  state_t    state, state_nxt;
  op_class_t op_class;
  logic      set_illegal;

  opcode_class_decode u_decode (
    .Opcode  (Opcode),
    .OpClass (op_class)
  );

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state   <= S_IF;
      Illegal <= 1'b0;
    end else if (!Stall) begin
      state <= state_nxt;
      if (set_illegal) Illegal <= 1'b1;
    end
  end

  // Opcode is stable from ID onward, so the live decode steers ID/EXE/MEM directly.
  always_comb begin
    state_nxt   = state;
    InsDone     = 1'b0;
    set_illegal = 1'b0;
    if (!Stall) begin
      case (state)
        S_IF: state_nxt = S_ID;
        S_ID: begin
          unique case (op_class)
            CLS_ALU, CLS_LOAD, CLS_STORE, CLS_BRANCH: state_nxt = S_EXE;
            CLS_JUMP: begin
              state_nxt = S_IF;
              InsDone   = 1'b1;
            end
            CLS_HALT: begin
              state_nxt = S_HALT;
              InsDone   = 1'b1;
            end
            default: begin
              state_nxt   = S_IF;
              InsDone     = 1'b1;
              set_illegal = 1'b1;
            end
          endcase
        end
        S_EXE: begin
          unique case (op_class)
            CLS_ALU:              state_nxt = S_WB;
            CLS_LOAD, CLS_STORE:  state_nxt = S_MEM;
            CLS_BRANCH: begin
              state_nxt = S_IF;
              InsDone   = 1'b1;
            end
            default:              state_nxt = S_IF;
          endcase
        end
        S_MEM: begin
          unique case (op_class)
            CLS_LOAD:  state_nxt = S_WB;
            CLS_STORE: begin
              state_nxt = S_IF;
              InsDone   = 1'b1;
            end
            default:   state_nxt = S_IF;
          endcase
        end
        S_WB: begin
          state_nxt = S_IF;
          InsDone   = 1'b1;
        end
        S_HALT: state_nxt = S_HALT;
        default: begin
          state_nxt   = S_IF;
          set_illegal = 1'b1;
        end
      endcase
    end
  end

  assign State  = state;
  assign Halted = (state == S_HALT);

`ifdef STATE_SEQ_PERF_CNT_EN
  always_ff @(posedge CLK) begin
    if (Reset) begin
      CycleCnt <= '0;
      InsCnt   <= '0;
    end else if (!Stall) begin
      CycleCnt <= CycleCnt + 1'b1;
      if (InsDone) InsCnt <= InsCnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_state_sequencer.sv
// Bench for state_sequencer: per-instruction route model plus directed scenarios.
module tb_state_sequencer;

  localparam int CW = 6;

  logic          CLK = 1'b0;
  logic          Reset = 1'b0;
  logic          Stall = 1'b0;
  logic [5:0]    Opcode = '0;
  logic [2:0]    State;
  logic          InsDone, Halted, Illegal;
`ifdef STATE_SEQ_PERF_CNT_EN
  logic [CW-1:0] CycleCnt, InsCnt;
`endif

  always #5 CLK = ~CLK;

  state_sequencer #(.CNT_W(CW)) dut (
    .CLK      (CLK),
    .Reset    (Reset),
    .Opcode   (Opcode),
    .Stall    (Stall),
    .State    (State),
    .InsDone  (InsDone),
    .Halted   (Halted),
    .Illegal  (Illegal)
`ifdef STATE_SEQ_PERF_CNT_EN
    ,
    .CycleCnt (CycleCnt),
    .InsCnt   (InsCnt)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Classes: 0 alu, 1 load, 2 store, 3 branch, 4 jump, 5 halt, 6 illegal
  function automatic int cls_of(logic [5:0] op);
    case (op)
      6'o00, 6'o01, 6'o02, 6'o20, 6'o21, 6'o22, 6'o30, 6'o46, 6'o47: return 0;
      6'o61: return 1;
      6'o60: return 2;
      6'o64, 6'o65, 6'o66: return 3;
      6'o70: return 4;
      6'o77: return 5;
      default: return 6;
    endcase
  endfunction

  // Sequence of states an instruction visits, element 0 in the low bits.
  function automatic logic [14:0] route(logic [5:0] op, output int len);
    case (cls_of(op))
      0: begin len = 4; return {3'd0, 3'b011, 3'b010, 3'b001, 3'b000}; end
      1: begin len = 5; return {3'b011, 3'b100, 3'b010, 3'b001, 3'b000}; end
      2: begin len = 4; return {3'd0, 3'b100, 3'b010, 3'b001, 3'b000}; end
      3: begin len = 3; return {6'd0, 3'b010, 3'b001, 3'b000}; end
      default: begin len = 2; return {9'd0, 3'b001, 3'b000}; end
    endcase
  endfunction

  int            m_pos = 0;
  bit            m_halt = 0, m_ill = 0, armed = 0;
  logic [CW-1:0] m_cyc = '0, m_ins = '0;
  int            p_len, c_len;
  logic [14:0]   p_r, c_r;

  always @(posedge CLK) begin
    p_r = route(Opcode, p_len);
    if (Reset) begin
      m_pos = 0; m_halt = 0; m_ill = 0; m_cyc = '0; m_ins = '0; armed = 1;
    end else if (!Stall) begin
      m_cyc = m_cyc + 1'b1;
      if (!m_halt) begin
        if (m_pos == p_len - 1) begin
          m_ins = m_ins + 1'b1;
          if (cls_of(Opcode) == 6) m_ill = 1;
          if (cls_of(Opcode) == 5) m_halt = 1;
          m_pos = 0;
        end else begin
          m_pos++;
        end
      end
    end
  end

  always @(negedge CLK) begin
    if (armed) begin
      c_r = route(Opcode, c_len);
      chk("state", {29'd0, State}, m_halt ? 32'd7 : {29'd0, c_r[3*m_pos +: 3]});
      chk("insdone", {31'd0, InsDone}, {31'd0, (!Stall && !m_halt && m_pos == c_len - 1)});
      chk("halted", {31'd0, Halted}, {31'd0, m_halt});
      chk("illegal", {31'd0, Illegal}, {31'd0, m_ill});
`ifdef STATE_SEQ_PERF_CNT_EN
      chk("cyclecnt", {26'd0, CycleCnt}, {26'd0, m_cyc});
      chk("inscnt", {26'd0, InsCnt}, {26'd0, m_ins});
`endif
    end
  end

  task automatic cyc(bit rst, bit st, logic [5:0] op);
    Reset = rst; Stall = st; Opcode = op;
    @(posedge CLK); #1;
  endtask

  task automatic run_seq(string name, logic [5:0] op, int n, logic [15:0] smask, logic [47:0] seq);
    for (int i = 0; i < n; i++) begin
      chk(name, {29'd0, State}, {29'd0, seq[3*i +: 3]});
      cyc(1'b0, smask[i], op);
    end
  endtask

  task automatic chk_cnt(string name, int cyc_exp, int ins_exp);
`ifdef STATE_SEQ_PERF_CNT_EN
    chk({name, "_cyc"}, {26'd0, CycleCnt}, cyc_exp);
    chk({name, "_ins"}, {26'd0, InsCnt}, ins_exp);
`else
    if (cyc_exp < 0 || ins_exp < 0) $display("negative count in %s", name);
`endif
  endtask

  logic [5:0] sweep [15] = '{6'o00, 6'o01, 6'o02, 6'o20, 6'o21, 6'o22, 6'o30, 6'o46,
                             6'o47, 6'o65, 6'o66, 6'o03, 6'o76, 6'o62, 6'o71};

  initial begin
    int len;
    logic [14:0] r;

    cyc(1'b1, 1'b0, 6'o00);
    chk("rst_state", {29'd0, State}, 32'd0);
    chk("rst_halted", {31'd0, Halted}, 32'd0);
    chk("rst_illegal", {31'd0, Illegal}, 32'd0);
    chk_cnt("rst", 0, 0);

    run_seq("add_seq", 6'o00, 4, 16'h0000, {36'd0, 3'b011, 3'b010, 3'b001, 3'b000});
    chk("add_end", {29'd0, State}, 32'd0);
    chk_cnt("add", 4, 1);

    run_seq("lw_seq", 6'o61, 7, 16'h0018,
            {27'd0, 3'b011, 3'b100, 3'b100, 3'b100, 3'b010, 3'b001, 3'b000});
    chk("lw_end", {29'd0, State}, 32'd0);

    cyc(1'b1, 1'b0, 6'o00);
    run_seq("beq_seq", 6'o64, 3, 16'h0000, {39'd0, 3'b010, 3'b001, 3'b000});
    run_seq("j_seq", 6'o70, 2, 16'h0000, {42'd0, 3'b001, 3'b000});
    chk("bj_end", {29'd0, State}, 32'd0);
    chk_cnt("bj", 5, 2);

    cyc(1'b1, 1'b0, 6'o00);
    run_seq("ill_seq", 6'o52, 2, 16'h0000, {42'd0, 3'b001, 3'b000});
    chk("ill_set", {31'd0, Illegal}, 32'd1);
    chk("ill_state", {29'd0, State}, 32'd0);
    run_seq("ill_add", 6'o00, 4, 16'h0000, {36'd0, 3'b011, 3'b010, 3'b001, 3'b000});
    chk("ill_sticky", {31'd0, Illegal}, 32'd1);

    run_seq("sw_stall", 6'o60, 6, 16'h0005,
            {30'd0, 3'b100, 3'b010, 3'b001, 3'b001, 3'b000, 3'b000});
    chk("sw_end", {29'd0, State}, 32'd0);

    cyc(1'b1, 1'b0, 6'o00);
    chk("ill_clear", {31'd0, Illegal}, 32'd0);

    foreach (sweep[k]) begin
      r = route(sweep[k], len);
      repeat (len) cyc(1'b0, 1'b0, sweep[k]);
    end

    cyc(1'b1, 1'b0, 6'o00);
    run_seq("halt_seq", 6'o77, 2, 16'h0000, {42'd0, 3'b001, 3'b000});
    for (int i = 0; i < 70; i++) begin
      chk("halt_state", {29'd0, State}, 32'd7);
      chk("halt_flag", {31'd0, Halted}, 32'd1);
      cyc(1'b0, (i == 5), 6'o77);
    end
    chk_cnt("halt", 7, 1);
    cyc(1'b1, 1'b0, 6'o77);
    chk("halt_exit", {29'd0, State}, 32'd0);
    chk("halt_exit_flag", {31'd0, Halted}, 32'd0);

    run_seq("sw_pre", 6'o60, 2, 16'h0000, {42'd0, 3'b001, 3'b000});
    chk("sw_exe", {29'd0, State}, 32'd2);
    Reset = 1'b1; Stall = 1'b1; Opcode = 6'o60;
    #1 chk("sw_rst_done", {31'd0, InsDone}, 32'd0);
    @(posedge CLK); #1;
    chk("sw_rst_state", {29'd0, State}, 32'd0);
    chk("sw_rst_ill", {31'd0, Illegal}, 32'd0);
    chk_cnt("sw_rst", 0, 0);
    cyc(1'b0, 1'b0, 6'o00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
